// File: rtl/vc_test_rand_delay.sv
// -----------------------------------------------------------------------------
// vc_test_rand_delay
//
// Single-entry val/rdy stage for unit-test harnesses. It accepts one message,
// holds it for a pseudo-random number of cycles (0..p_max_delay), then offers
// it downstream. Content and order are preserved. The delay sequence is fixed
// by p_seed, so a given seed always reproduces the same timing.
//
// Handshake: a transfer happens on a rising edge where valid and ready are both
// high. The sender never waits on ready before raising valid. Once valid is
// raised, the message stays unchanged until it transfers. Ready may depend
// combinationally on the receiver's ready (in_rdy follows out_rdy in HOLD).
// Valid never depends on ready.
//
// Parameters:
//   p_msg_nbits  message width in bits
//   p_max_delay  largest inserted delay in cycles (0..255)
//   p_seed       non-zero reset value of the 16-bit LFSR
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_val     upstream message valid
//   in_rdy     stage can take a message this cycle
//   in_msg     upstream message
//   out_val    buffered message is valid downstream
//   out_rdy    downstream ready
//   out_msg    buffered message (meaningful only while out_val is high)
//   dbg_state  current FSM state (0 IDLE, 1 DELAY, 2 HOLD)
// -----------------------------------------------------------------------------
module vc_test_rand_delay #(
    parameter int unsigned p_msg_nbits = 1,
    parameter int unsigned p_max_delay = 0,
    parameter logic [15:0] p_seed      = 16'h0001
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   in_val,
    output logic                   in_rdy,
    input  logic [p_msg_nbits-1:0] in_msg,
    output logic                   out_val,
    input  logic                   out_rdy,
    output logic [p_msg_nbits-1:0] out_msg,
    output logic [1:0]             dbg_state
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_DELAY = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic [15:0]            lfsr_q, lfsr_d;
    logic [7:0]             count_q, count_d;
    logic [p_msg_nbits-1:0] buf_q, buf_d;

    logic [15:0]            lfsr_next;
    logic [7:0]             delay_new;
    logic                   in_fire;

    // Fibonacci LFSR, taps 16/14/13/11 (bits 15, 13, 12, 10).
    assign lfsr_next = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};

    // Delay for a message accepted this cycle. It uses the LFSR value before
    // the advance. A 9-bit modulus lets p_max_delay = 255 divide by 256.
    generate
        if (p_max_delay == 0) begin : g_no_delay
            assign delay_new = 8'd0;
        end else begin : g_mod_delay
            localparam logic [8:0] MODULUS = 9'(p_max_delay + 1);
            assign delay_new = 8'({1'b0, lfsr_q[7:0]} % MODULUS);
        end
    endgenerate

    assign in_fire = in_val && in_rdy;

    always_comb begin
        state_d = state_q;
        lfsr_d  = lfsr_q;
        count_d = count_q;
        buf_d   = buf_q;
        in_rdy  = 1'b0;
        out_val = 1'b0;

        case (state_q)
            ST_IDLE: begin
                in_rdy = 1'b1;
            end
            ST_DELAY: begin
                // count is at least 1 here; the last delay cycle moves on to HOLD.
                count_d = count_q - 8'd1;
                if (count_q == 8'd1) begin
                    state_d = ST_HOLD;
                end
            end
            ST_HOLD: begin
                out_val = 1'b1;
                // The slot frees up in the same cycle the message leaves.
                in_rdy  = out_rdy;
                if (out_rdy) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        // While reset is high, neither side may see a handshake.
        if (reset) begin
            in_rdy  = 1'b0;
            out_val = 1'b0;
        end

        // A new message overrides the IDLE or HOLD next state chosen above.
        if (in_val && in_rdy) begin
            buf_d   = in_msg;
            count_d = delay_new;
            lfsr_d  = lfsr_next;
            state_d = (delay_new == 8'd0) ? ST_HOLD : ST_DELAY;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= ST_IDLE;
            lfsr_q  <= p_seed;
            count_q <= 8'd0;
            buf_q   <= '0;
        end else begin
            state_q <= state_d;
            lfsr_q  <= lfsr_d;
            count_q <= count_d;
            buf_q   <= buf_d;
        end
    end

    assign out_msg   = buf_q;
    assign dbg_state = state_q;

    // in_fire is kept as a named term for waveform readability.
    logic unused_ok;
    assign unused_ok = in_fire;

endmodule

// File: tb/tb_vc_test_rand_delay.sv
// -----------------------------------------------------------------------------
// tb_vc_test_rand_delay
//
// Three copies of the stage run side by side:
//   lane 0: p_max_delay = 0,   seed 0001
//   lane 1: p_max_delay = 3,   seed 0001
//   lane 2: p_max_delay = 255, seed ACE1
// The reference model is timestamp based. Each accepted message gets a
// presentation cycle (accept + 1 + d). Here d is taken from a model LFSR and
// reduced modulo (p_max_delay + 1). The monitor compares every cycle.
// -----------------------------------------------------------------------------
module tb_vc_test_rand_delay;

    localparam int W = 13;
    localparam int NL = 3;

    // Clock/reset
    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic         in_val    [NL];
    logic         in_rdy    [NL];
    logic [W-1:0] in_msg    [NL];
    logic         out_val   [NL];
    logic         out_rdy   [NL];
    logic [W-1:0] out_msg   [NL];
    logic [1:0]   dbg_state [NL];

    vc_test_rand_delay #(.p_msg_nbits(W), .p_max_delay(0), .p_seed(16'h0001)) u_dut0 (
        .clk(clk), .reset(reset),
        .in_val(in_val[0]), .in_rdy(in_rdy[0]), .in_msg(in_msg[0]),
        .out_val(out_val[0]), .out_rdy(out_rdy[0]), .out_msg(out_msg[0]),
        .dbg_state(dbg_state[0])
    );

    vc_test_rand_delay #(.p_msg_nbits(W), .p_max_delay(3), .p_seed(16'h0001)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_val(in_val[1]), .in_rdy(in_rdy[1]), .in_msg(in_msg[1]),
        .out_val(out_val[1]), .out_rdy(out_rdy[1]), .out_msg(out_msg[1]),
        .dbg_state(dbg_state[1])
    );

    vc_test_rand_delay #(.p_msg_nbits(W), .p_max_delay(255), .p_seed(16'hACE1)) u_dut2 (
        .clk(clk), .reset(reset),
        .in_val(in_val[2]), .in_rdy(in_rdy[2]), .in_msg(in_msg[2]),
        .out_val(out_val[2]), .out_rdy(out_rdy[2]), .out_msg(out_msg[2]),
        .dbg_state(dbg_state[2])
    );

    function automatic int lane_maxd(input int k);
        case (k)
            0:       return 0;
            1:       return 3;
            default: return 255;
        endcase
    endfunction

    function automatic logic [15:0] lane_seed(input int k);
        return (k == 2) ? 16'hACE1 : 16'h0001;
    endfunction

    function automatic logic [15:0] lfsr_step(input logic [15:0] l);
        return {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
    endfunction

    // Scoreboard
    typedef struct {
        int           lane;
        logic [W-1:0] msg;
        int           t_acc;
    } sb_entry_t;

    sb_entry_t exp_q[$];
    int        obs_q[$];

    int n_compared   = 0;
    int n_mismatched = 0;

    bit          m_busy      [NL];
    int          m_present   [NL];
    logic [15:0] m_lfsr      [NL];
    bit          head_seen   [NL];
    int          n_delivered [NL];

    bit end_req      = 1'b0;
    bit end_done     = 1'b0;
    int drv_timeouts = 0;

    task automatic check(input string name, input int k, input logic [31:0] act,
                         input logic [31:0] exp);
        n_compared++;
        if (act !== exp) begin
            n_mismatched++;
            $display("FAIL %s lane%0d cycle %0d: got %0h expected %0h", name, k, cyc, act, exp);
        end
    endtask

    function automatic int find_head(input int k);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (exp_q[i].lane == k) return i;
        end
        return -1;
    endfunction

    task automatic lane_step(input int k);
        int        idx;
        bit        exp_ov;
        bit        exp_ir;
        int        exp_st;
        int        d;
        sb_entry_t e;
        idx = find_head(k);
        if (reset) begin
            check("in_rdy_in_reset", k, 32'(in_rdy[k]), 32'd0);
            check("out_val_in_reset", k, 32'(out_val[k]), 32'd0);
            m_busy[k]    = 1'b0;
            m_lfsr[k]    = lane_seed(k);
            head_seen[k] = 1'b0;
            for (int i = exp_q.size() - 1; i >= 0; i--) begin
                if (exp_q[i].lane == k) exp_q.delete(i);
            end
        end else begin
            exp_ov = m_busy[k] && (cyc >= m_present[k]);
            exp_ir = !m_busy[k] || (exp_ov && out_rdy[k]);
            exp_st = !m_busy[k] ? 0 : (exp_ov ? 2 : 1);
            check("in_rdy", k, 32'(in_rdy[k]), 32'(exp_ir));
            check("out_val", k, 32'(out_val[k]), 32'(exp_ov));
            check("state", k, 32'(dbg_state[k]), 32'(exp_st));
            if (exp_ov && idx >= 0) begin
                check("out_msg", k, 32'(out_msg[k]), 32'(exp_q[idx].msg));
            end
            if (idx >= 0 && out_val[k] && !head_seen[k]) begin
                head_seen[k] = 1'b1;
                if (k == 1) obs_q.push_back(cyc - exp_q[idx].t_acc - 1);
            end
            if (exp_ov && out_rdy[k] && idx >= 0) begin
                exp_q.delete(idx);
                m_busy[k]    = 1'b0;
                head_seen[k] = 1'b0;
                n_delivered[k]++;
            end
            if (in_val[k] && exp_ir) begin
                d       = int'(m_lfsr[k][7:0]) % (lane_maxd(k) + 1);
                e.lane  = k;
                e.msg   = in_msg[k];
                e.t_acc = cyc;
                exp_q.push_back(e);
                m_busy[k]    = 1'b1;
                m_present[k] = cyc + 1 + d;
                m_lfsr[k]    = lfsr_step(m_lfsr[k]);
            end
        end
    endtask

    task automatic end_checks();
        int left;
        int exp_d[4] = '{1, 2, 0, 0};
        for (int k = 0; k < NL; k++) begin
            left = 0;
            for (int i = 0; i < exp_q.size(); i++) begin
                if (exp_q[i].lane == k) left++;
            end
            check("undelivered", k, 32'(left), 32'd0);
            check("delivered_any", k, 32'(n_delivered[k] != 0), 32'd1);
        end
        check("driver_timeouts", 0, 32'(drv_timeouts), 32'd0);
        for (int i = 0; i < 4; i++) begin
            check("seed_delay", 1, (i < obs_q.size()) ? 32'(obs_q[i]) : 32'hffff_ffff,
                  32'(exp_d[i]));
        end
    endtask

    // Monitor: model update and comparison at the falling edge.
    initial begin
        for (int k = 0; k < NL; k++) begin
            m_busy[k]      = 1'b0;
            m_present[k]   = 0;
            m_lfsr[k]      = lane_seed(k);
            head_seen[k]   = 1'b0;
            n_delivered[k] = 0;
        end
        while (!end_done) begin
            @(negedge clk);
            if (end_req) begin
                end_checks();
                end_done = 1'b1;
            end else begin
                for (int k = 0; k < NL; k++) lane_step(k);
            end
        end
    end

    // Driver tasks
    bit fired [NL];

    task automatic step();
        @(negedge clk);
        for (int k = 0; k < NL; k++) fired[k] = in_val[k] && in_rdy[k];
        @(posedge clk);
        #1;
    endtask

    task automatic send(input int k, input logic [W-1:0] msg, input logic ordy);
        int n;
        n = 0;
        in_val[k]  = 1'b1;
        in_msg[k]  = msg;
        out_rdy[k] = ordy;
        do begin
            step();
            n++;
        end while (!fired[k] && n < 400);
        if (!fired[k]) drv_timeouts++;
        in_val[k] = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    initial begin
        logic [W-1:0] seq_a[6] = '{13'h0aa, 13'h0bb, 13'h0cc, 13'h0dd, 13'h0ee, 13'h0ff};
        logic [W-1:0] seq_b[4] = '{13'h011, 13'h022, 13'h033, 13'h044};
        for (int k = 0; k < NL; k++) begin
            in_val[k]  = 1'b0;
            in_msg[k]  = '0;
            out_rdy[k] = 1'b0;
        end
        reset = 1'b1;
        idle(3);
        reset = 1'b0;
        idle(2);

        // Back-to-back traffic with zero delay: one message per cycle.
        for (int i = 0; i < 6; i++) send(0, seq_a[i], 1'b1);
        idle(3);

        // Seeded delays on the p_max_delay = 3 lane.
        for (int i = 0; i < 4; i++) send(1, seq_b[i], 1'b1);
        idle(6);

        // Backpressure: stall 5 cycles while a competing message waits.
        send(0, 13'h11aa, 1'b0);
        in_val[0] = 1'b1;
        in_msg[0] = 13'h1fff;
        idle(5);
        in_val[0]  = 1'b0;
        out_rdy[0] = 1'b1;
        idle(3);

        // Leave and arrive in the same HOLD cycle.
        send(0, 13'h02bb, 1'b1);
        send(0, 13'h13cc, 1'b1);
        idle(3);

        // Reset while lanes 1 and 2 are still delaying.
        reset = 1'b1;
        idle(2);
        reset = 1'b0;
        in_val[1]  = 1'b1; in_msg[1]  = 13'h0077; out_rdy[1] = 1'b1;
        in_val[2]  = 1'b1; in_msg[2]  = 13'h0155; out_rdy[2] = 1'b1;
        step();
        in_val[1] = 1'b0;
        in_val[2] = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        idle(2);
        send(1, 13'h0078, 1'b1);
        send(2, 13'h0156, 1'b1);
        idle(4);

        // Randomized traffic on all lanes, with one reset in the middle.
        for (int i = 0; i < 2500; i++) begin
            for (int k = 0; k < NL; k++) begin
                in_val[k]  = ($urandom_range(0, 1) == 1);
                in_msg[k]  = W'($urandom);
                out_rdy[k] = ($urandom_range(0, 3) != 0);
            end
            reset = (i == 1200);
            step();
        end
        reset = 1'b0;

        // Drain everything still in flight.
        for (int k = 0; k < NL; k++) begin
            in_val[k]  = 1'b0;
            out_rdy[k] = 1'b1;
        end
        idle(300);

        end_req = 1'b1;
        repeat (3) @(posedge clk);
        if (!end_done) begin
            n_compared++;
            n_mismatched++;
            $display("FAIL end_checks lane0: got 0 expected 1 (end checks never ran)");
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/vc_test_rand_delay.md
Name: vc_test_rand_delay

Overview:
- Single-entry val/rdy stage inserted between a test source and a test sink.
- Accepts one message and holds it internally for a pseudo-random number of cycles, then presents it downstream.
- Purpose: stress latency-insensitive handshakes in unit-test harnesses.
- Message content and order are preserved exactly. Delay sequence is deterministic for a given seed.

Parameters:
- p_msg_nbits, 1: message width in bits.
- p_max_delay, 0: maximum inserted delay in cycles, legal range 0..255.
- p_seed, 16'h0001: LFSR reset value; must be nonzero.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- in_val  input  1  upstream message valid.
- in_rdy  output  1  stage can accept a message this cycle.
- in_msg  input  p_msg_nbits  upstream message.
- out_val  output  1  buffered message valid downstream.
- out_rdy  input  1  downstream ready.
- out_msg  output  p_msg_nbits  buffered message.

Behaviour:
- Transfers: in fires when in_val && in_rdy; out fires when out_val && out_rdy.
- Reset: state=IDLE, lfsr=p_seed, count=0, buffer=0. While reset is high, in_rdy=0 and out_val=0. Reset mid-operation discards any buffered or delaying message.
- LFSR: 16-bit Fibonacci. fb = l[15]^l[13]^l[12]^l[10]; next = {l[14:0], fb}. Advances only on cycles where in fires.
- Delay computation: d = l[7:0] % (p_max_delay+1), taken from the pre-advance lfsr value in the accept cycle. When p_max_delay=0, d is always 0 and no modulo logic is needed.
- States: IDLE, DELAY, HOLD.
- IDLE:
  - in_rdy=1, out_val=0.
  - On in fire: buffer<=in_msg, count<=d; go to HOLD if d==0, else DELAY.
- DELAY:
  - in_rdy=0, out_val=0.
  - count decrements each cycle; when count==1, go to HOLD.
  - The stage spends exactly d cycles in DELAY.
- HOLD:
  - out_val=1, out_msg=buffer. in_rdy=out_rdy (combinational rdy-to-rdy path).
  - out fire with no in fire: go to IDLE.
  - out fire and in fire in the same cycle: latch the new message, compute a new d, go to HOLD or DELAY as in IDLE.
  - out_val stays high and out_msg stays stable while out_rdy=0 (no drop, no change).
- Latency: a message accepted at the edge ending cycle t has out_val=1 from cycle t+1+d.
- Throughput: with p_max_delay=0 and out_rdy held high, one message per cycle sustained.
- out_msg outside HOLD is don't-care; the bench must not check it.
- No combinational path from in_val/in_msg to out_val/out_msg.

Test Plan:
- p_max_delay=0, p_msg_nbits=8, out_rdy=1, source sends 8'haa, bb, cc, dd, ee, ff back-to-back → sink receives the same six values in order, one per cycle, first out_val one cycle after the first accept.
- p_max_delay=3, p_seed=16'h0001, out_rdy=1, msgs 8'h11, 22, 33, 44 → delays 1, 2, 0, 0 (lfsr 0001, 0002, 0004, 0008); out_val rises at accept+2, accept+3, accept+1, accept+1; in_rdy=0 during DELAY.
- Backpressure: p_max_delay=0, msg 13'h11aa in HOLD, out_rdy=0 for 5 cycles → out_val=1 and out_msg=13'h11aa stable all 5 cycles, in_rdy=0; then out_rdy=1 → out fires once and state returns to IDLE.
- Simultaneous in/out in HOLD with p_max_delay=0: 13'h02bb leaving while 13'h13cc arrives → next cycle out_msg=13'h13cc, out_val=1, no bubble.
- Reset mid-DELAY: p_max_delay=200, assert reset for 1 cycle while count>0 → out_val=0, in_rdy=0 during reset; after reset in_rdy=1; old message never appears; lfsr restarts at p_seed.
- Full harness: source → this block (p_max_delay=4) → sink with 6 messages → sink done asserts with no mismatches well before 5000 cycles.
